// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   WIDTH-bit add/subtract built from 4-bit carry-lookahead groups. Each group has one
//   register stage, and the carry ripples from stage to stage. The adder accepts one
//   operation per cycle. Both sides use valid/ready flow control, and one global enable
//   (ADV) freezes the whole pipeline when the output is stalled.
//
// Ports
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous reset, active-high
//   IN_VALID   in   1      A/B/C0/SUB valid
//   IN_READY   out  1      input accepted this cycle when IN_VALID=1
//   A, B       in   WIDTH  operands
//   C0         in   1      carry-in (ignored when SUB=1)
//   SUB        in   1      0: F=A+B+C0, 1: F=A-B
//   OUT_VALID  out  1      result valid
//   OUT_READY  in   1      downstream accepts result
//   F          out  WIDTH  sum/difference
//   C_OUT      out  1      carry out of MSB (SUB=1: 1 means no borrow)
//   OVF        out  1      two's-complement overflow
//   ZERO       out  1      F == 0

module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] F,
    output logic             C_OUT,
    output logic             OVF,
    output logic             ZERO
);

    localparam int unsigned STAGES = WIDTH / 4;

    // Returns {carry into bit 3, carry out of bit 3, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c3, c4, p ^ {c3, c2, c1, cin}};
    endfunction

    logic             w_adv;
    // Values entering stage k: the input port for k=0, otherwise stage k-1's registers.
    logic [WIDTH-1:0] w_a_in [STAGES];
    logic [WIDTH-1:0] w_b_in [STAGES];
    logic [WIDTH-1:0] w_s_in [STAGES];
    logic             w_c_in [STAGES];
    logic             w_v_in [STAGES];
    logic [5:0]       w_cla  [STAGES];
    logic [WIDTH-1:0] w_s_nx [STAGES];
    logic             w_ovf_nx;
    logic             w_zero_nx;

    // Stage registers: partial sum (low slices done), operands, carry, and valid.
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;
    logic             r_zero;

    assign w_adv    = ~r_v[STAGES-1] | OUT_READY;
    assign IN_READY = w_adv;

    always_comb begin
        w_a_in[0] = A;
        w_b_in[0] = SUB ? ~B : B;
        w_s_in[0] = '0;
        w_c_in[0] = SUB ? 1'b1 : C0;
        w_v_in[0] = IN_VALID;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_s[k-1];
            w_c_in[k] = r_c[k-1];
            w_v_in[k] = r_v[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_cla[k]            = cla4(w_a_in[k][4*k +: 4], w_b_in[k][4*k +: 4], w_c_in[k]);
            w_s_nx[k]           = w_s_in[k];
            w_s_nx[k][4*k +: 4] = w_cla[k][3:0];
        end
        // Signed overflow: carry into the MSB differs from carry out of it.
        w_ovf_nx  = w_cla[STAGES-1][5] ^ w_cla[STAGES-1][4];
        w_zero_nx = (w_s_nx[STAGES-1] == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
                r_s[k] <= w_s_nx[k];
                r_c[k] <= w_cla[k][4];
                r_v[k] <= w_v_in[k];
            end
            r_ovf  <= w_ovf_nx;
            r_zero <= w_zero_nx;
        end
    end

    assign OUT_VALID = r_v[STAGES-1];
    assign F         = r_s[STAGES-1];
    assign C_OUT     = r_c[STAGES-1];
    assign OVF       = r_ovf;
    assign ZERO      = r_zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder. It drives instances of width 4, 8, 16 and 32 from a
// shared clock and reset. Expected results come from a plain-arithmetic reference model.

module tb_pipelined_cla_adder;

    localparam int NI        = 4;
    localparam int STALL_LEN = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a    [NI];
    logic [31:0] b    [NI];
    logic        c0   [NI];
    logic        sub  [NI];
    logic        iv   [NI];
    logic        ordy [NI];
    wire  [31:0] o_f  [NI];
    wire         o_ir [NI];
    wire         o_v  [NI];
    wire         o_c  [NI];
    wire         o_ovf[NI];
    wire         o_z  [NI];

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [31:0] f;
        logic        c;
        logic        ovf;
        logic        z;
    } res_t;

    res_t exp_q [NI][$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = 4 << g;
        logic [W-1:0] w_f;
        pipelined_cla_adder #(.WIDTH(W)) u_dut (
            .CLK      (clk),
            .RST      (rst),
            .IN_VALID (iv[g]),
            .IN_READY (o_ir[g]),
            .A        (a[g][W-1:0]),
            .B        (b[g][W-1:0]),
            .C0       (c0[g]),
            .SUB      (sub[g]),
            .OUT_VALID(o_v[g]),
            .OUT_READY(ordy[g]),
            .F        (w_f),
            .C_OUT    (o_c[g]),
            .OVF      (o_ovf[g]),
            .ZERO     (o_z[g])
        );
        assign o_f[g] = 32'(w_f);
    end

    function automatic int wd(input int i);
        return 4 << i;
    endfunction

    // Reference: widen, add, then read carry, sign rule for overflow, and zero test.
    function automatic res_t model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                   input logic cc, input logic ss);
        longint unsigned mask;
        longint unsigned av;
        longint unsigned bv;
        longint unsigned sum;
        res_t            r;
        mask  = (64'd1 << w) - 64'd1;
        av    = {32'd0, aa} & mask;
        bv    = {32'd0, (ss ? ~bb : bb)} & mask;
        sum   = av + bv + (ss ? 64'd1 : {63'd0, cc});
        r.f   = 32'(sum & mask);
        r.c   = sum[w];
        r.ovf = (av[w-1] == bv[w-1]) && (sum[w-1] != av[w-1]);
        r.z   = ((sum & mask) == 64'd0);
        return r;
    endfunction

    function automatic res_t observe(input int i);
        res_t r;
        r.f   = o_f[i];
        r.c   = o_c[i];
        r.ovf = o_ovf[i];
        r.z   = o_z[i];
        return r;
    endfunction

    task automatic drive_rand(input int i);
        int sel;
        sel    = $urandom_range(0, 7);
        a[i]   = (sel == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        b[i]   = (sel == 1) ? 32'd0 : ((sel == 2) ? a[i] : 32'($urandom));
        c0[i]  = 1'($urandom);
        sub[i] = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (o_v[i] !== 1'b0 || o_ir[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_flags w%0d: OUT_VALID=%b IN_READY=%b, required 0/1",
                         wd(i), o_v[i], o_ir[i]);
            end
            vectors++;
            if (observe(i) !== '0) begin
                errors++;
                $display("FAIL reset_outputs w%0d: F=%h C=%b OVF=%b Z=%b, required all 0",
                         wd(i), o_f[i], o_c[i], o_ovf[i], o_z[i]);
            end
        end
    endtask

    task automatic test_directed();
        typedef struct packed {
            logic [1:0]  idx;
            logic [31:0] a;
            logic [31:0] b;
            logic        c0;
            logic        sub;
            res_t        r;
        } dvec_t;
        dvec_t tbl [9];
        int    i;
        int    st;
        res_t  obs;
        tbl[0] = '{2'd0, 32'h4,        32'h3,    1'b0, 1'b0, '{32'h7,        1'b0, 1'b0, 1'b0}};
        tbl[1] = '{2'd0, 32'hF,        32'hF,    1'b0, 1'b0, '{32'hE,        1'b1, 1'b0, 1'b0}};
        tbl[2] = '{2'd0, 32'hA,        32'h5,    1'b1, 1'b0, '{32'h0,        1'b1, 1'b0, 1'b1}};
        tbl[3] = '{2'd2, 32'hFFFF,     32'h1,    1'b0, 1'b0, '{32'h0,        1'b1, 1'b0, 1'b1}};
        tbl[4] = '{2'd2, 32'h7FFF,     32'h1,    1'b0, 1'b0, '{32'h8000,     1'b0, 1'b1, 1'b0}};
        tbl[5] = '{2'd2, 32'h5,        32'h7,    1'b0, 1'b1, '{32'hFFFE,     1'b0, 1'b0, 1'b0}};
        tbl[6] = '{2'd2, 32'h8000,     32'h1,    1'b0, 1'b1, '{32'h7FFF,     1'b1, 1'b1, 1'b0}};
        tbl[7] = '{2'd1, 32'h10,       32'h10,   1'b1, 1'b1, '{32'h0,        1'b1, 1'b0, 1'b1}};
        tbl[8] = '{2'd3, 32'hFFFFFFFF, 32'h1,    1'b0, 1'b0, '{32'h0,        1'b1, 1'b0, 1'b1}};
        for (int n = 0; n < 9; n++) begin
            i      = int'(tbl[n].idx);
            st     = wd(i) / 4;
            a[i]   = tbl[n].a;
            b[i]   = tbl[n].b;
            c0[i]  = tbl[n].c0;
            sub[i] = tbl[n].sub;
            iv[i]  = 1'b1;
            for (int e = 0; e < st; e++) begin
                if (e == st - 1) begin
                    vectors++;
                    if (o_v[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL latency_early vec%0d: OUT_VALID=%b after %0d edges, required 0",
                                 n, o_v[i], e);
                    end
                end
                @(posedge clk);
                #1;
                iv[i] = 1'b0;
            end
            vectors++;
            if (o_v[i] !== 1'b1) begin
                errors++;
                $display("FAIL latency vec%0d: OUT_VALID=%b after %0d edges, required 1",
                         n, o_v[i], st);
            end
            obs = observe(i);
            vectors++;
            if (obs !== tbl[n].r) begin
                errors++;
                $display("FAIL directed vec%0d w%0d: F=%h C=%b OVF=%b Z=%b, required F=%h C=%b OVF=%b Z=%b",
                         n, wd(i), obs.f, obs.c, obs.ovf, obs.z,
                         tbl[n].r.f, tbl[n].r.c, tbl[n].r.ovf, tbl[n].r.z);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int          i = 2;
        int          issued = 0;
        int          got = 0;
        int          stall_cnt = 0;
        int          cyc = 0;
        logic        acc;
        logic [31:0] held_f = '0;
        res_t        exp_r;
        res_t        obs;
        exp_q[i].delete();
        drive_rand(i);
        iv[i]   = 1'b1;
        ordy[i] = 1'b1;
        while ((issued < 20 || exp_q[i].size() != 0) && cyc < 200) begin
            @(negedge clk);
            if (o_v[i] && ordy[i]) begin
                obs = observe(i);
                vectors++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: result F=%h with nothing outstanding", obs.f);
                end else begin
                    exp_r = exp_q[i].pop_front();
                    got++;
                    if (obs !== exp_r) begin
                        errors++;
                        $display("FAIL stream_data #%0d: F=%h C=%b OVF=%b Z=%b, required F=%h C=%b OVF=%b Z=%b",
                                 got, obs.f, obs.c, obs.ovf, obs.z,
                                 exp_r.f, exp_r.c, exp_r.ovf, exp_r.z);
                    end
                end
            end
            if (!ordy[i]) begin
                stall_cnt++;
                vectors++;
                if (o_ir[i] !== 1'b0 || o_v[i] !== 1'b1 || o_f[i] !== held_f) begin
                    errors++;
                    $display("FAIL stall_hold: IN_READY=%b OUT_VALID=%b F=%h, required 0/1/%h",
                             o_ir[i], o_v[i], o_f[i], held_f);
                end
            end
            acc = iv[i] && o_ir[i];
            if (acc) begin
                exp_q[i].push_back(model(16, a[i], b[i], c0[i], sub[i]));
                issued++;
            end
            @(posedge clk);
            #1;
            cyc++;
            ordy[i] = !(cyc >= 10 && cyc < 10 + STALL_LEN);
            if (cyc == 10) held_f = o_f[i];
            if (acc) begin
                if (issued < 20) drive_rand(i);
                else iv[i] = 1'b0;
            end
        end
        iv[i]   = 1'b0;
        ordy[i] = 1'b1;
        vectors++;
        if (got != 20 || stall_cnt != STALL_LEN) begin
            errors++;
            $display("FAIL stream_count: results=%0d stall_cycles=%0d, required 20/%0d",
                     got, stall_cnt, STALL_LEN);
        end
        vectors++;
        if (cyc != 20 + STALL_LEN + 4) begin
            errors++;
            $display("FAIL stream_rate: %0d cycles used, required %0d", cyc, 20 + STALL_LEN + 4);
        end
    endtask

    task automatic test_reset_mid();
        int   i = 2;
        res_t exp_r;
        res_t obs;
        for (int n = 0; n < 3; n++) begin
            drive_rand(i);
            iv[i] = 1'b1;
            @(posedge clk);
            #1;
        end
        iv[i] = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            vectors++;
            if (o_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush cycle%0d: OUT_VALID=%b, required 0", n, o_v[i]);
            end
            @(posedge clk);
            #1;
        end
        drive_rand(i);
        exp_r = model(16, a[i], b[i], c0[i], sub[i]);
        iv[i] = 1'b1;
        for (int e = 0; e < 4; e++) begin
            if (e == 3) begin
                vectors++;
                if (o_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL post_reset_early: OUT_VALID=%b after 3 edges, required 0", o_v[i]);
                end
            end
            @(posedge clk);
            #1;
            iv[i] = 1'b0;
        end
        obs = observe(i);
        vectors++;
        if (o_v[i] !== 1'b1 || obs !== exp_r) begin
            errors++;
            $display("FAIL post_reset_op: OUT_VALID=%b F=%h C=%b OVF=%b Z=%b, required 1 F=%h C=%b OVF=%b Z=%b",
                     o_v[i], obs.f, obs.c, obs.ovf, obs.z, exp_r.f, exp_r.c, exp_r.ovf, exp_r.z);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic acc;
        res_t exp_r;
        res_t obs;
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            drive_rand(i);
            iv[i]   = ($urandom_range(0, 9) < 7);
            ordy[i] = ($urandom_range(0, 9) < 7);
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                vectors++;
                if (o_ir[i] !== (!o_v[i] || ordy[i])) begin
                    errors++;
                    $display("FAIL rand_ready w%0d cyc%0d: IN_READY=%b, required %b",
                             wd(i), cyc, o_ir[i], !o_v[i] || ordy[i]);
                end
                if (o_v[i] && ordy[i]) begin
                    obs = observe(i);
                    vectors++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL rand_extra w%0d cyc%0d: F=%h with nothing outstanding",
                                 wd(i), cyc, obs.f);
                    end else begin
                        exp_r = exp_q[i].pop_front();
                        if (obs !== exp_r) begin
                            errors++;
                            $display("FAIL rand_data w%0d cyc%0d: F=%h C=%b OVF=%b Z=%b, required F=%h C=%b OVF=%b Z=%b",
                                     wd(i), cyc, obs.f, obs.c, obs.ovf, obs.z,
                                     exp_r.f, exp_r.c, exp_r.ovf, exp_r.z);
                        end
                    end
                end
                acc = iv[i] && o_ir[i];
                if (acc) exp_q[i].push_back(model(wd(i), a[i], b[i], c0[i], sub[i]));
                @(posedge clk);
                #1;
                if (!iv[i] || acc) begin
                    drive_rand(i);
                    iv[i] = (cyc < 300) && ($urandom_range(0, 9) < 7);
                end
                ordy[i] = ($urandom_range(0, 9) < 7);
            end
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
            vectors++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL rand_drain w%0d: %0d results never emitted, required 0",
                         wd(i), exp_q[i].size());
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            a[i]    = '0;
            b[i]    = '0;
            c0[i]   = 1'b0;
            sub[i]  = 1'b0;
            iv[i]   = 1'b0;
            ordy[i] = 1'b1;
        end
        rst = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
